// File: rtl/pilha_pkg.sv
// Shared types and defaults for the operand-stack read path.
// Holds the scan state encoding and the count saturation helper.
package pilha_pkg;

  localparam int PROFUNDIDADE_PADRAO = 4;
  localparam int LARGURA_PADRAO      = 8;

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    ENDERECA  = 3'd1,
    CAPTURA   = 3'd2,
    APRESENTA = 3'd3,
    FIM       = 3'd4
  } estado_t;

  // The stack may report more entries than it physically holds; clamp to depth.
  function automatic int unsigned satura_contagem(input int unsigned n, input int unsigned limite);
    return (n > limite) ? limite : n;
  endfunction

endpackage

// File: rtl/contador_indice.sv
// Loadable index counter: holds the scan limit, clears/advances the index
// and flags when the index sits on the last valid entry (limit - 1).
module contador_indice
  import pilha_pkg::*;
#(
  parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO,
  parameter int LARG_IDX     = $clog2(PROFUNDIDADE)
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                limpa,
  input  logic                carrega,
  input  logic                habilita,
  input  logic [LARG_IDX:0]   limite,
  output logic [LARG_IDX-1:0] idx,
  output logic                terminal
);

  logic [LARG_IDX:0] total_reg;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      idx       <= '0;
      total_reg <= '0;
    end else begin
      if (carrega) begin
        total_reg <= limite;
      end
      if (limpa) begin
        idx <= '0;
      end else if (habilita && !terminal) begin
        // Index stops on the last entry; it never wraps.
        idx <= idx + 1'b1;
      end
    end
  end

  assign terminal = ({1'b0, idx} == (total_reg - 1'b1));

endmodule

// File: rtl/leitor_pilha.sv
// Read-side scanner for the operand stack: walks entries from TOS down
// through the indexed read port and hands each one out over valid/ready.
module leitor_pilha
  import pilha_pkg::*;
#(
  parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO,
  parameter int LARGURA      = LARGURA_PADRAO,
  parameter int LARG_IDX     = $clog2(PROFUNDIDADE)
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                inicia,
  input  logic                cancela,
  input  logic [LARG_IDX:0]   num_validos,
  output logic [LARG_IDX-1:0] end_leitura,
  input  logic [LARGURA-1:0]  dado_pilha,
  output logic [LARGURA-1:0]  dado_saida,
  output logic [LARG_IDX-1:0] indice,
  output logic                dado_valido,
  input  logic                dado_aceito,
  output logic                ocupado,
  output logic                concluido
);

  estado_t               estado_reg;
  logic [LARG_IDX:0]     total_sat;
  logic [LARG_IDX-1:0]   idx;
  logic                  terminal;
  logic                  partida;
  logic                  avanca;

  assign total_sat = (LARG_IDX+1)'(satura_contagem(32'(num_validos), PROFUNDIDADE));
  assign partida   = (estado_reg == OCIOSO) && inicia && !cancela;
  assign avanca    = (estado_reg == APRESENTA) && dado_aceito && !cancela;

  contador_indice #(
    .PROFUNDIDADE (PROFUNDIDADE),
    .LARG_IDX     (LARG_IDX)
  ) u_contador (
    .Clk      (Clk),
    .Reset    (Reset),
    .limpa    (partida),
    .carrega  (partida),
    .habilita (avanca),
    .limite   (total_sat),
    .idx      (idx),
    .terminal (terminal)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      estado_reg  <= OCIOSO;
      end_leitura <= '0;
      dado_saida  <= '0;
      indice      <= '0;
      dado_valido <= 1'b0;
      ocupado     <= 1'b0;
      concluido   <= 1'b0;
    end else begin
      concluido <= 1'b0;
      if (cancela && (estado_reg != OCIOSO)) begin
        // Abort: dado_saida keeps its last value, no completion pulse.
        estado_reg  <= OCIOSO;
        dado_valido <= 1'b0;
        ocupado     <= 1'b0;
      end else begin
        case (estado_reg)
          OCIOSO: begin
            if (partida) begin
              ocupado <= 1'b1;
              if (total_sat == '0) begin
                estado_reg <= FIM;
              end else begin
                // Address goes out while in ENDERECA so data is back for CAPTURA.
                end_leitura <= '0;
                estado_reg  <= ENDERECA;
              end
            end
          end
          ENDERECA: begin
            estado_reg <= CAPTURA;
          end
          CAPTURA: begin
            dado_saida  <= dado_pilha;
            indice      <= idx;
            dado_valido <= 1'b1;
            estado_reg  <= APRESENTA;
          end
          APRESENTA: begin
            if (dado_aceito) begin
              dado_valido <= 1'b0;
              if (terminal) begin
                estado_reg <= FIM;
              end else begin
                end_leitura <= idx + 1'b1;
                estado_reg  <= ENDERECA;
              end
            end
          end
          FIM: begin
            concluido  <= 1'b1;
            ocupado    <= 1'b0;
            estado_reg <= OCIOSO;
          end
          default: begin
            estado_reg  <= OCIOSO;
            dado_valido <= 1'b0;
            ocupado     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_leitor_pilha.sv
// Randomized bench for leitor_pilha: each scan is predicted as an ordered
// list of (index, stack word) pairs with fixed gap/handshake timing.
module tb_leitor_pilha;

  localparam int PROF = 4;
  localparam int LARG = 8;
  localparam int LI   = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            inicia = 1'b0;
  logic            cancela = 1'b0;
  logic [LI:0]     num_validos = '0;
  logic [LI-1:0]   end_leitura;
  logic [LARG-1:0] dado_pilha = '0;
  logic [LARG-1:0] dado_saida;
  logic [LI-1:0]   indice;
  logic            dado_valido;
  logic            dado_aceito = 1'b0;
  logic            ocupado;
  logic            concluido;

  logic [LARG-1:0] mem [PROF];

  int total = 0;
  int bad   = 0;

  leitor_pilha #(.PROFUNDIDADE(PROF), .LARGURA(LARG)) dut (
    .Clk         (clk),
    .Reset       (rst_n),
    .inicia      (inicia),
    .cancela     (cancela),
    .num_validos (num_validos),
    .end_leitura (end_leitura),
    .dado_pilha  (dado_pilha),
    .dado_saida  (dado_saida),
    .indice      (indice),
    .dado_valido (dado_valido),
    .dado_aceito (dado_aceito),
    .ocupado     (ocupado),
    .concluido   (concluido)
  );

  always #5 clk = ~clk;

  // Stack read port with one cycle of latency.
  always @(posedge clk) dado_pilha <= mem[end_leitura];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs apply to the cycle that starts now; returns mid-cycle for sampling.
  task automatic drive_cycle(input logic ini, input logic can, input logic ace,
                             input logic [LI:0] nv, input logic rst = 1'b1);
    @(posedge clk);
    #1;
    inicia      = ini;
    cancela     = can;
    dado_aceito = ace;
    num_validos = nv;
    rst_n       = rst;
    @(negedge clk);
  endtask

  function automatic logic [LI:0] rnd_nv();
    return (LI+1)'($urandom_range(7, 0));
  endfunction

  function automatic logic rnd_bit();
    return logic'($urandom_range(1, 0));
  endfunction

  task automatic end_sequence();
    drive_cycle(1'b0, 1'b0, 1'b0, rnd_nv());
    chk("fim_ocupado", ocupado, 1);
    chk("fim_concluido_cedo", concluido, 0);
    drive_cycle(1'b0, 1'b0, 1'b0, rnd_nv());
    chk("concluido", concluido, 1);
    chk("ocupado_apos_fim", ocupado, 0);
    chk("valido_apos_fim", dado_valido, 0);
    drive_cycle(1'b0, 1'b0, 1'b0, rnd_nv());
    chk("concluido_unico", concluido, 0);
  endtask

  task automatic scan(input int nv, input int stall_lo, input int stall_hi,
                      input int cancel_idx, input bit fixed);
    int n;
    int k;
    logic [LARG-1:0] q[$];
    logic last;
    logic can;
    logic ace;
    if (!fixed) for (int i = 0; i < PROF; i++) mem[i] = LARG'($urandom);
    n = (nv > PROF) ? PROF : nv;
    q = {};
    for (int i = 0; i < n; i++) q.push_back(mem[i]);
    $display("scan start nv=%0d entries=%0d cancel_at=%0d", nv, n, cancel_idx);
    drive_cycle(1'b1, 1'b0, rnd_bit(), (LI+1)'(nv));
    chk("idle_ocupado", ocupado, 0);
    if (n == 0) begin
      drive_cycle(1'b0, 1'b0, rnd_bit(), rnd_nv());
      chk("zero_ocupado", ocupado, 1);
      chk("zero_valido", dado_valido, 0);
      chk("zero_concluido_cedo", concluido, 0);
      drive_cycle(1'b0, 1'b0, 1'b0, rnd_nv());
      chk("zero_concluido", concluido, 1);
      chk("zero_ocupado_fim", ocupado, 0);
      chk("zero_valido_fim", dado_valido, 0);
      drive_cycle(1'b0, 1'b0, 1'b0, rnd_nv());
      chk("zero_concluido_unico", concluido, 0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      drive_cycle(rnd_bit(), 1'b0, rnd_bit(), rnd_nv());
      chk("gap1_valido", dado_valido, 0);
      chk("gap1_ocupado", ocupado, 1);
      chk("end_leitura", end_leitura, i);
      drive_cycle(rnd_bit(), 1'b0, rnd_bit(), rnd_nv());
      chk("gap2_valido", dado_valido, 0);
      k = $urandom_range(stall_hi, stall_lo);
      for (int s = 0; s <= k; s++) begin
        last = (s == k);
        can  = last && (i == cancel_idx);
        ace  = last ? (can ? rnd_bit() : 1'b1) : 1'b0;
        drive_cycle(rnd_bit(), can, ace, rnd_nv());
        chk("valido", dado_valido, 1);
        chk("dado_saida", dado_saida, q[i]);
        chk("indice", indice, i);
        chk("concluido_meio", concluido, 0);
        if (last) $display("xfer indice=%0d dado=%02h stall=%0d aceito=%0b cancela=%0b",
                           indice, dado_saida, k, ace, can);
      end
      if (i == cancel_idx) begin
        drive_cycle(1'b0, 1'b0, 1'b0, rnd_nv());
        chk("cancel_valido", dado_valido, 0);
        chk("cancel_ocupado", ocupado, 0);
        chk("cancel_concluido", concluido, 0);
        chk("cancel_mantem_dado", dado_saida, q[i]);
        drive_cycle(1'b0, 1'b0, 1'b0, rnd_nv());
        chk("cancel_sem_concluido", concluido, 0);
        return;
      end
    end
    end_sequence();
  endtask

  initial begin
    for (int i = 0; i < PROF; i++) mem[i] = '0;

    drive_cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
    drive_cycle(1'b1, 1'b0, 1'b1, 3'd4, 1'b0);
    chk("rst_end_leitura", end_leitura, 0);
    chk("rst_dado_saida", dado_saida, 0);
    chk("rst_indice", indice, 0);
    chk("rst_valido", dado_valido, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_concluido", concluido, 0);
    drive_cycle(1'b0, 1'b0, 1'b0, '0);

    mem[0] = 8'h2A; mem[1] = 8'h11; mem[2] = 8'h07; mem[3] = 8'hFF;
    scan(4, 0, 0, -1, 1'b1);

    // Reset while the first entry is being captured.
    drive_cycle(1'b1, 1'b0, 1'b0, 3'd4);
    chk("rs_idle", ocupado, 0);
    drive_cycle(1'b0, 1'b0, 1'b0, 3'd4);
    chk("rs_end_leitura", end_leitura, 0);
    chk("rs_ocupado", ocupado, 1);
    drive_cycle(1'b0, 1'b0, 1'b0, 3'd4, 1'b0);
    chk("rs_captura_valido", dado_valido, 0);
    drive_cycle(1'b0, 1'b0, 1'b1, 3'd4, 1'b0);
    chk("rs_dado_saida", dado_saida, 0);
    chk("rs_indice", indice, 0);
    chk("rs_end_leitura0", end_leitura, 0);
    chk("rs_valido", dado_valido, 0);
    chk("rs_ocupado0", ocupado, 0);
    chk("rs_concluido", concluido, 0);
    scan(4, 0, 1, -1, 1'b1);

    scan(0, 0, 0, -1, 1'b0);
    scan(2, 5, 5, -1, 1'b1);
    scan(4, 2, 2, 1, 1'b0);
    scan(4, 0, 1, -1, 1'b0);
    scan(7, 0, 2, -1, 1'b0);

    // Start and cancel together while idle: cancel wins.
    drive_cycle(1'b1, 1'b1, 1'b0, 3'd3);
    chk("ic_idle", ocupado, 0);
    drive_cycle(1'b0, 1'b0, 1'b0, 3'd3);
    chk("ic_ocupado", ocupado, 0);
    chk("ic_valido", dado_valido, 0);
    drive_cycle(1'b0, 1'b0, 1'b0, 3'd3);
    chk("ic_concluido", concluido, 0);

    for (int r = 0; r < 25; r++) begin
      int nv;
      int canc;
      nv   = $urandom_range(7, 0);
      canc = ($urandom_range(3, 0) == 0) ? $urandom_range(PROF-1, 0) : -1;
      scan(nv, 0, 3, canc, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/leitor_pilha.md
Name: leitor_pilha

Overview:
Read-side controller for the calculator's operand stack. The existing path only pushes into the stack and exposes TOS/NOS.
This block walks the stack contents from TOS downward through an indexed read port and hands each entry to a consumer (display scroller or serial transmitter) over a valid/ready handshake.
It sits beside the stack in the top level, runs on the divided clock, and is started by the control unit.

Parameters:
PROFUNDIDADE, 4, number of stack entries (power of 2, >=2)
LARGURA, 8, data width of one entry
LARG_IDX, $clog2(PROFUNDIDADE), index width (derived, not overridden)

Ports:
Clk  input  1  divided system clock (clk_lento); all logic on rising edge
Reset  input  1  synchronous, active-low reset
inicia  input  1  one-cycle start pulse from control unit
cancela  input  1  abort current scan
num_validos  input  LARG_IDX+1  count of occupied entries (0..PROFUNDIDADE), sampled at start
end_leitura  output  LARG_IDX  read address to stack (0 = TOS)
dado_pilha  input  LARGURA  stack read data, valid 1 cycle after end_leitura
dado_saida  output  LARGURA  entry presented to consumer
indice  output  LARG_IDX  position of dado_saida (0 = TOS)
dado_valido  output  1  dado_saida/indice valid
dado_aceito  input  1  consumer ready; transfer when dado_valido & dado_aceito
ocupado  output  1  scan in progress
concluido  output  1  one-cycle pulse at scan end (normal or zero entries; not on cancel)

Behaviour:
- Reset (Reset=0 at edge): state OCIOSO; end_leitura=0, dado_saida=0, indice=0, dado_valido=0, ocupado=0, concluido=0; latched count cleared. Reset overrides every other input, including mid-scan.
- States: OCIOSO, ENDERECA, CAPTURA, APRESENTA, FIM.
- OCIOSO: on inicia=1, latch num_validos into total, clear idx.
  - total=0: go to FIM.
  - otherwise: go to ENDERECA.
  - ocupado=0 only in OCIOSO.
- ENDERECA: end_leitura=idx; go to CAPTURA next cycle. This covers the 1-cycle read latency.
- CAPTURA: register dado_pilha into dado_saida and idx into indice; set dado_valido=1; go to APRESENTA.
- APRESENTA: hold dado_saida, indice and dado_valido=1 stable until dado_aceito=1.
  - On transfer: dado_valido=0 next cycle.
  - If idx=total-1: go to FIM.
  - Else: idx+1, go to ENDERECA.
- FIM: concluido=1 for exactly one cycle, ocupado=0 in the following cycle, return to OCIOSO.
- Latency: inicia to first dado_valido = 3 cycles. Back-to-back with dado_aceito held high = 3 cycles per entry.
- dado_aceito before dado_valido has no effect. No combinational path from dado_aceito to any output.
- inicia while ocupado=1: ignored.
- inicia and cancela together in OCIOSO: cancela wins, stays OCIOSO.
- cancela=1 in any non-OCIOSO state: next cycle OCIOSO, dado_valido=0, no concluido pulse. dado_saida keeps its last value.
- cancela in the same cycle as a transfer: the transfer counts, scan still aborts.
- num_validos > PROFUNDIDADE: saturate total to PROFUNDIDADE.
- Changes to num_validos or stack contents during a scan are not tracked. Count is fixed at start; data is whatever the port returns when read.
- idx never wraps. Scan ends at total-1.

Decomposition:
- Shared package (pilha_pkg): state encoding constants (OCIOSO..FIM, 3-bit), LARGURA and PROFUNDIDADE defaults, the saturation helper for count.
- One natural sub-module: contador_indice. Loadable index counter with clear, enable and terminal-compare output (idx==total-1). Reused later by any stack pop logic.
- FSM and output registers stay in leitor_pilha.

Test Plan:
- Reset then idle, stack {TOS=0x2A, 0x11, 0x07, 0xFF}, num_validos=4, dado_aceito=1, pulse inicia -> dado_valido at cycle+3 with 0x2A/indice 0, then 0x11, 0x07, 0xFF every 3 cycles; concluido pulse once after last; ocupado low after.
- num_validos=0, pulse inicia -> no dado_valido; concluido=1 exactly 2 cycles after inicia edge; ocupado high only 1 cycle.
- num_validos=2, dado_aceito low 5 cycles after first valid -> dado_saida=0x2A, indice=0 held stable all 5 cycles; second entry 0x11 appears 3 cycles after acceptance.
- Mid-scan cancela during APRESENTA of indice 1 -> dado_valido=0 next cycle, state OCIOSO, no concluido; new inicia restarts from indice 0.
- inicia re-pulsed during scan and num_validos=7 with PROFUNDIDADE=4 -> second inicia ignored; exactly 4 entries emitted.
- Reset=0 asserted during CAPTURA -> all outputs 0 at next edge; after release, inicia produces a normal full scan.
